control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Parametrised multi-cycle instruction sequencer; next generation of the controlpath FSM.
- Sits between the instruction/data memory interfaces and the existing alu_instruction_decoder / mmu_decoder.
- Adds explicit fetch/decode/execute/memory/writeback phases, a stall watchdog, fault-cause reporting, halt-at-boundary semantics and a retired-instruction counter.

Parameters:
- WAIT_TIMEOUT, 255: consecutive stall cycles in FETCH or MEM before a timeout fault; 0 disables the watchdog.
- TO_W, 8: width of the stall counter; must satisfy 2^TO_W > WAIT_TIMEOUT.
- RET_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- go  in  1  start, resume, or clear-fault request
- halt  in  1  halt request
- instr_class  in  2  {instr_pc, instr_alu} = instruction[1:0], valid in DECODE
- ld  in  1  decoded load
- st  in  1  decoded store
- invalid_instruction  in  1  muxed decoder invalid flag
- instr_segv  in  1  instruction fetch fault
- data_segv  in  1  data access fault
- wait_instr  in  1  instruction memory stall
- wait_data  in  1  data memory stall
- fetch_req  out  1  instruction fetch active
- ir_load  out  1  latch instruction register this edge
- exec_en  out  1  ALU operation cycle
- mem_req  out  1  data access active
- reg_write_en  out  1  register file write strobe
- pc_inc  out  1  PC += 1
- pc_load  out  1  PC takes branch target
- halted  out  1  in HALTED
- fault  out  1  in FAULT
- fault_cause  out  3  0 none, 1 instr_segv, 2 data_segv, 3 invalid, 4 timeout
- current_state  out  3  state encoding
- retired  out  RET_W  instructions completed, saturating

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, FAULT=7.
- Reset (resetn=0 at posedge): state IDLE; every output 0; halt_pending, stall counter, fault_cause and retired all 0. Reset mid-operation aborts immediately; no write or PC strobe fires in the reset cycle.
- Strobes are decoded combinationally from the current state and inputs, with no added latency. fault_cause and retired are registered.
- halt_pending is set by halt=1 in any state except HALTED and FAULT. It is cleared on entry to HALTED.
- IDLE:
  - halt or halt_pending -> HALTED.
  - else go -> FETCH.
  - else stay.
- FETCH: fetch_req=1. Priority order:
  1. instr_segv -> FAULT, cause 1.
  2. wait_instr with watchdog expired -> FAULT, cause 4.
  3. wait_instr -> stay.
  4. otherwise ir_load=1 this cycle -> DECODE.
- DECODE:
  - invalid_instruction -> FAULT, cause 3.
  - else ld or st -> MEM.
  - else -> EXEC.
  - ld and st both set is treated as invalid (cause 3).
- EXEC: exec_en=1 for exactly one cycle -> WB.
- MEM: mem_req=1. Same priority order as FETCH, using data_segv (cause 2) and wait_data (cause 4). Otherwise -> WB.
- WB:
  - reg_write_en=1 unless the instruction was a store.
  - pc_load=1 if instr_pc (latched in DECODE), else pc_inc=1.
  - retired increments, saturating at all-ones.
  - Next state is HALTED if halt_pending or halt, else FETCH.
- HALTED: halted=1.
  - go=1 and halt=0 -> FETCH.
  - go and halt both high -> stay (halt wins).
- FAULT: fault=1; fault_cause holds its value.
  - go=1 and halt=0 -> IDLE, fault_cause cleared to 0.
  - Otherwise sticky.
- Halt never aborts an in-flight instruction; it is honoured only in IDLE or at the end of WB.
- Watchdog:
  - Stall counter clears on entry to FETCH or MEM, and on any cycle where the relevant wait is 0.
  - It increments each cycle the wait is 1.
  - Expiry occurs when counter == WAIT_TIMEOUT-1 and the wait is still 1, so exactly WAIT_TIMEOUT stalled cycles fault.
  - WAIT_TIMEOUT=0 means never expire.
- Unused encodings are unreachable. Any illegal state value goes to FAULT with cause 0.

Optional Feature:
- Macro: CONTROL_SEQUENCER_SINGLE_STEP_EN.
- When defined:
  - Extra input step_mode (1 bit) is present.
  - With step_mode=1, WB always goes to HALTED after retiring.
  - Each go pulse then executes exactly one instruction.
- When undefined: the port is absent and behaviour is as specified above.

Test Plan:
- ALU instruction: resetn low 2 cycles, go=1, wait_instr=0, instr_class=2'b01 -> states 1,2,3,5,1 over 4 cycles; exec_en, reg_write_en and pc_inc each pulse once; retired=1.
- Load with 3-cycle wait_data -> mem_req high for 4 cycles, then reg_write_en pulse; store -> no reg_write_en; branch instr_class=2'b10 -> pc_load=1, pc_inc=0.
- WAIT_TIMEOUT=4, wait_instr held high -> FAULT after exactly 4 FETCH cycles with fault_cause=4; a 3-cycle stall must not fault.
- halt pulsed during EXEC -> instruction completes (reg_write_en fires), then HALTED; go+halt together -> stays HALTED; go alone -> FETCH.
- instr_segv in FETCH -> FAULT cause 1; invalid_instruction in DECODE -> cause 3; ld=st=1 -> cause 3; go -> IDLE with cause 0.
- Saturation: RET_W=2, run 5 instructions -> retired sticks at 3; resetn low mid-MEM -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Port bundle between control_sequencer and the memory/decoder side.
// Optional step_mode input exists only when CONTROL_SEQUENCER_SINGLE_STEP_EN is defined.
interface control_sequencer_if #(
  parameter int RET_W = 16
);
  // go/halt are level requests sampled every clock; each strobe output is a
  // single-cycle qualifier that is meaningful only in the cycle it is high.
  logic             go;
  logic             halt;
  logic [1:0]       instr_class;
  logic             ld;
  logic             st;
  logic             invalid_instruction;
  logic             instr_segv;
  logic             data_segv;
  logic             wait_instr;
  logic             wait_data;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  logic             step_mode;
`endif
  logic             fetch_req;
  logic             ir_load;
  logic             exec_en;
  logic             mem_req;
  logic             reg_write_en;
  logic             pc_inc;
  logic             pc_load;
  logic             halted;
  logic             fault;
  logic [2:0]       fault_cause;
  logic [2:0]       current_state;
  logic [RET_W-1:0] retired;

  modport slave (
    input  go, halt, instr_class, ld, st, invalid_instruction,
           instr_segv, data_segv, wait_instr, wait_data,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    input  step_mode,
`endif
    output fetch_req, ir_load, exec_en, mem_req, reg_write_en, pc_inc,
           pc_load, halted, fault, fault_cause, current_state, retired
  );

  modport master (
    output go, halt, instr_class, ld, st, invalid_instruction,
           instr_segv, data_segv, wait_instr, wait_data,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    output step_mode,
`endif
    input  fetch_req, ir_load, exec_en, mem_req, reg_write_en, pc_inc,
           pc_load, halted, fault, fault_cause, current_state, retired
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with stall watchdog,
// fault causes, halt-at-boundary and a saturating retired counter. Option: CONTROL_SEQUENCER_SINGLE_STEP_EN.
module control_sequencer #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int TO_W         = 8,
  parameter int RET_W        = 16
) (
  input  logic                clk,
  input  logic                resetn,
  control_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam int              TO_LAST_I = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

  state_t           r_state;
  logic             r_halt_pending;
  logic             r_is_store;
  logic             r_is_pc;
  logic [TO_W-1:0]  r_stall;
  logic [2:0]       r_cause;
  logic [RET_W-1:0] r_retired;

  logic w_step;
  logic w_wait;
  logic w_segv;
  logic w_expire;
  logic w_unused_alu;

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  assign w_step = bus.step_mode;
`else
  assign w_step = 1'b0;
`endif

  // FETCH and MEM share one watchdog; the state picks which memory side it watches.
  assign w_wait       = (r_state == S_MEM) ? bus.wait_data : bus.wait_instr;
  assign w_segv       = (r_state == S_MEM) ? bus.data_segv : bus.instr_segv;
  assign w_expire     = (WAIT_TIMEOUT != 0) && (r_stall == TO_LAST);
  assign w_unused_alu = bus.instr_class[0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_halt_pending <= 1'b0;
      r_is_store     <= 1'b0;
      r_is_pc        <= 1'b0;
      r_stall        <= '0;
      r_cause        <= 3'd0;
      r_retired      <= '0;
    end else begin
      if (bus.halt && (r_state != S_HALTED) && (r_state != S_FAULT))
        r_halt_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.halt || r_halt_pending) begin
            r_state        <= S_HALTED;
            r_halt_pending <= 1'b0;
          end else if (bus.go) begin
            r_state <= S_FETCH;
            r_stall <= '0;
          end
        end
        S_FETCH, S_MEM: begin
          if (w_segv) begin
            r_state <= S_FAULT;
            r_cause <= (r_state == S_MEM) ? 3'd2 : 3'd1;
          end else if (w_wait) begin
            if (w_expire) begin
              r_state <= S_FAULT;
              r_cause <= 3'd4;
            end else begin
              r_stall <= r_stall + 1'b1;
            end
          end else begin
            r_stall <= '0;
            r_state <= (r_state == S_MEM) ? S_WB : S_DECODE;
          end
        end
        S_DECODE: begin
          r_is_pc    <= bus.instr_class[1];
          r_is_store <= bus.st;
          if (bus.invalid_instruction || (bus.ld && bus.st)) begin
            r_state <= S_FAULT;
            r_cause <= 3'd3;
          end else if (bus.ld || bus.st) begin
            r_state <= S_MEM;
            r_stall <= '0;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: r_state <= S_WB;
        S_WB: begin
          if (r_retired != {RET_W{1'b1}})
            r_retired <= r_retired + 1'b1;
          if (r_halt_pending || bus.halt || w_step) begin
            r_state        <= S_HALTED;
            r_halt_pending <= 1'b0;
          end else begin
            r_state <= S_FETCH;
            r_stall <= '0;
          end
        end
        S_HALTED: begin
          if (bus.go && !bus.halt) begin
            r_state <= S_FETCH;
            r_stall <= '0;
          end
        end
        S_FAULT: begin
          if (bus.go && !bus.halt) begin
            r_state <= S_IDLE;
            r_cause <= 3'd0;
          end
        end
        default: begin
          r_state <= S_FAULT;
          r_cause <= 3'd0;
        end
      endcase
    end
  end

  logic w_fetch_req, w_ir_load, w_exec_en, w_mem_req;
  logic w_reg_write_en, w_pc_inc, w_pc_load, w_halted, w_fault;

  // Strobes are forced low while resetn is asserted so nothing fires on the reset edge.
  always_comb begin
    w_fetch_req    = 1'b0;
    w_ir_load      = 1'b0;
    w_exec_en      = 1'b0;
    w_mem_req      = 1'b0;
    w_reg_write_en = 1'b0;
    w_pc_inc       = 1'b0;
    w_pc_load      = 1'b0;
    w_halted       = 1'b0;
    w_fault        = 1'b0;
    if (resetn) begin
      case (r_state)
        S_FETCH: begin
          w_fetch_req = 1'b1;
          w_ir_load   = !bus.instr_segv && !bus.wait_instr;
        end
        S_EXEC:   w_exec_en = 1'b1;
        S_MEM:    w_mem_req = 1'b1;
        S_WB: begin
          w_reg_write_en = !r_is_store;
          w_pc_load      = r_is_pc;
          w_pc_inc       = !r_is_pc;
        end
        S_HALTED: w_halted = 1'b1;
        S_FAULT:  w_fault  = 1'b1;
        default:  ;
      endcase
    end
  end

  assign bus.fetch_req     = w_fetch_req;
  assign bus.ir_load       = w_ir_load;
  assign bus.exec_en       = w_exec_en;
  assign bus.mem_req       = w_mem_req;
  assign bus.reg_write_en  = w_reg_write_en;
  assign bus.pc_inc        = w_pc_inc;
  assign bus.pc_load       = w_pc_load;
  assign bus.halted        = w_halted;
  assign bus.fault         = w_fault;
  assign bus.fault_cause   = r_cause;
  assign bus.current_state = r_state;
  assign bus.retired       = r_retired;

endmodule
